// File: rtl/sobol_gen.sv
// One-dimensional Sobol source: Gray-code recurrence over a loadable 32x32 direction table,
// emitting u in (0,1) as unsigned Q-format fractions over a valid/ready handshake.
module sobol_gen #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned QINT  = 16,
   parameter int unsigned QFRAC = 16,
   parameter int unsigned CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    dir_we,
   input  logic [4:0]              dir_addr,
   input  logic [31:0]             dir_data,
   input  logic                    start,
   input  logic [CNT_W-1:0]        n_points,
   output logic                    busy,
   output logic                    done,
   output logic                    valid_out,
   input  logic                    ready_in,
   output logic signed [WIDTH-1:0] u_out
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [31:0]      x_q, x_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] u_q, u_d;

   logic [31:0]      dir_tab [32];

   logic [31:0]      idx_ext;
   logic [4:0]       dir_sel;
   logic [31:0]      x_next;
   logic [QFRAC-1:0] frac;
   logic [WIDTH-1:0] u_next;
   logic             load;
   logic             xfer;
   logic             drain;

   // Index of the lowest zero bit, saturating at 31.
   function automatic logic [4:0] trailing_ones(input logic [31:0] v);
      logic [4:0] n;
      logic       stop;
      n    = '0;
      stop = 1'b0;
      for (int i = 0; i < 31; i++) begin
         if (!stop && v[i]) begin
            n = n + 5'd1;
         end else begin
            stop = 1'b1;
         end
      end
      return n;
   endfunction

   // Table has no reset so that it survives a mid-run reset.
   always_ff @(posedge clk) begin
      if (dir_we && (state_q == StIdle)) begin
         dir_tab[dir_addr] <= dir_data;
      end
   end

   always_comb begin
      idx_ext = 32'(idx_q);
      dir_sel = trailing_ones(idx_ext);
      x_next  = x_q ^ dir_tab[dir_sel];
      frac    = x_next[31 -: QFRAC];
      // Zero would map to -inf downstream, so clamp to one LSB.
      if (frac == '0) begin
         u_next = WIDTH'(1);
      end else begin
         u_next = WIDTH'({{QINT{1'b0}}, frac});
      end
   end

   assign xfer  = valid_q && ready_in;
   assign drain = !valid_q || ready_in;
   assign load  = (state_q == StRun) && (rem_q != '0) && drain;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      valid_d = valid_q;
      u_d     = u_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               rem_d   = n_points;
               x_d     = '0;
               idx_d   = '0;
            end
         end
         StRun: begin
            if (load) begin
               x_d     = x_next;
               idx_d   = idx_q + CNT_W'(1);
               rem_d   = rem_q - CNT_W'(1);
               valid_d = 1'b1;
               u_d     = u_next;
            end else if (xfer) begin
               valid_d = 1'b0;
            end
            if ((rem_q == '0) && drain) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         x_q     <= '0;
         idx_q   <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
         u_q     <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
         u_q     <= u_d;
      end
   end

   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign valid_out = valid_q;
   assign u_out     = u_q;

endmodule

// File: tb/tb_sobol_gen.sv
// Randomized scoreboard bench for sobol_gen; expected samples come from the closed-form
// Gray-code Sobol definition x_n = XOR of v_k over the set bits of n ^ (n >> 1).
module tb_sobol_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dir_we = 1'b0;
   logic [4:0]  dir_addr = '0;
   logic [31:0] dir_data = '0;
   logic        start = 1'b0;
   logic [31:0] n_points = '0;
   logic        busy;
   logic        done;
   logic        valid_out;
   logic        ready_in = 1'b1;
   logic signed [31:0] u_out;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model_tab [32];
   bit          rand_ready = 1'b0;

   sobol_gen #(
      .WIDTH (32),
      .QINT  (16),
      .QFRAC (16),
      .CNT_W (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dir_we    (dir_we),
      .dir_addr  (dir_addr),
      .dir_data  (dir_data),
      .start     (start),
      .n_points  (n_points),
      .busy      (busy),
      .done      (done),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .u_out     (u_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
      end
   endtask

   function automatic logic [31:0] model_u(input int unsigned n);
      logic [31:0] g;
      logic [31:0] x;
      g = 32'(n) ^ (32'(n) >> 1);
      x = '0;
      for (int k = 0; k < 32; k++) begin
         if (g[k]) x = x ^ model_tab[k];
      end
      if (x[31:16] == 16'h0) return 32'h1;
      return {16'h0, x[31:16]};
   endfunction

   // Mode 0: van der Corput, 1: all zero, 2: random sparse
   task automatic load_table(input int mode);
      logic [31:0] v;
      for (int k = 0; k < 32; k++) begin
         case (mode)
            0: v = 32'h8000_0000 >> k;
            1: v = '0;
            default: v = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         endcase
         model_tab[k] = v;
         @(posedge clk); #1;
         dir_we = 1'b1; dir_addr = 5'(k); dir_data = v;
      end
      @(posedge clk); #1;
      dir_we = 1'b0;
   endtask

   // Returns 1ns after the edge that samples start.
   task automatic start_pulse(input int unsigned n);
      for (int unsigned i = 1; i <= n; i++) exp_q.push_back(model_u(i));
      @(posedge clk); #1;
      start = 1'b1; n_points = n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (done) break;
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL done_timeout: no done pulse within %0d cycles", budget);
      end else begin
         check("busy_at_done", {31'b0, busy}, 32'd1);
         check("valid_at_done", {31'b0, valid_out}, 32'd0);
         @(negedge clk);
         check("done_one_cycle", {31'b0, done}, 32'd0);
         check("busy_after_done", {31'b0, busy}, 32'd0);
         check("queue_drained", exp_q.size(), 32'd0);
      end
   endtask

   task automatic run(input int unsigned n, input bit b2b);
      int cyc;
      start_pulse(n);
      @(negedge clk);
      check("busy_after_start", {31'b0, busy}, 32'd1);
      check("valid_latency0", {31'b0, valid_out}, 32'd0);
      if (n > 0) begin
         @(negedge clk);
         check("valid_latency1", {31'b0, valid_out}, 32'd1);
         if (b2b) begin
            for (int unsigned i = 2; i <= n; i++) begin
               @(negedge clk);
               check("b2b_valid", {31'b0, valid_out}, 32'd1);
            end
         end
      end
      wait_done(8 * n + 50, cyc);
      if (n == 0 || b2b) check("done_timing", cyc, 32'd1);
   endtask

   // Scoreboard monitor: pops on each transfer and checks stall stability.
   initial begin : monitor
      logic        stall_prev;
      logic [31:0] u_prev;
      stall_prev = 1'b0;
      u_prev = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check("stall_hold_u", u_out, u_prev);
               check("stall_hold_valid", {31'b0, valid_out}, 32'd1);
            end
            if (valid_out && ready_in) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL unexpected_sample: got 0x%08h with empty queue", u_out);
               end else begin
                  check("sample", u_out, exp_q.pop_front());
               end
            end
            stall_prev = valid_out && !ready_in;
            u_prev = u_out;
         end
      end
   end

   initial begin : ready_driver
      forever begin
         @(posedge clk); #1;
         if (rand_ready) ready_in = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int cyc;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'b0, valid_out}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_u", u_out, 32'd0);
      rst_n = 1'b1;

      // Van der Corput, free-flowing
      load_table(0);
      ready_in = 1'b1;
      run(4, 1'b1);

      // Stall while the second sample is presented
      start_pulse(8);
      @(posedge clk); #1;
      @(posedge clk); #1;
      ready_in = 1'b0;
      check("stall_second", u_out, 32'h0000_C000);
      repeat (3) @(posedge clk);
      #1;
      check("stall_second_end", u_out, 32'h0000_C000);
      ready_in = 1'b1;
      wait_done(100, cyc);

      // All-zero table hits the clamp
      load_table(1);
      run(3, 1'b1);

      // Empty run
      run(0, 1'b0);

      // start and table write mid-run are ignored
      load_table(0);
      start_pulse(10);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; n_points = 3; dir_we = 1'b1; dir_addr = 5'd0; dir_data = 32'h0;
      @(posedge clk); #1;
      start = 1'b0; dir_we = 1'b0;
      wait_done(100, cyc);
      run(2, 1'b1);

      // Asynchronous reset in the middle of the third sample
      start_pulse(5);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_valid", {31'b0, valid_out}, 32'd1);
      check("pre_rst_u", u_out, 32'h0000_4000);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", {31'b0, valid_out}, 32'd0);
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_u", u_out, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      run(2, 1'b1);

      // Random tables, lengths and backpressure
      rand_ready = 1'b1;
      for (int it = 0; it < 8; it++) begin
         load_table(2);
         run($urandom_range(1, 40), 1'b0);
      end
      rand_ready = 1'b0;
      @(posedge clk); #1;
      ready_in = 1'b1;
      run($urandom_range(0, 1), 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
